tenkey_scan: RTL and testbench
==============================

Name: tenkey_scan

Overview:
- Keypad front end that produces the one-hot `tenkey` digit stream and the `close` strobe consumed by the electronic lock core.
- Scans a 4x3 membrane matrix (digits 0-9, '*', '#') and debounces it.
- Emits exactly one single-cycle pulse per physical key press.
- Sits between the board keypad pins and the lock; both outputs are registered.

Parameters:
SCAN_DIV, 8, clk cycles each row is driven before its columns are sampled; must be >= 4 (covers synchronizer latency)
DEBOUNCE_N, 4, consecutive identical scan frames required to accept a press, and also to accept a release; must be >= 1

Ports:
clk      input   1   system clock
reset    input   1   asynchronous, active-high reset
col_n    input   3   keypad column lines, active-low (board pull-ups), asynchronous to clk
row_n    output  4   keypad row drive, active-low, exactly one bit low at any time
tenkey   output  10  one-hot digit pulse: bit d high for one clk when digit d is accepted
close    output  1   one-clk pulse when '#' is accepted
busy     output  1   high while a key is being debounced or held (state != IDLE)

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- Reset values: row_n=4'b1110, tenkey=0, close=0, busy=0, state=IDLE, all counters 0.
- Key map (row, col0..col2):
  - row0 = 1,2,3
  - row1 = 4,5,6
  - row2 = 7,8,9
  - row3 = *,0,#
- col_n passes through a 2-FF synchronizer before any use.
- Prescaler counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1: sample the synced col_n for the current row, then rotate row_n to the next row (wrap row3->row0).
  - Frame = 4*SCAN_DIV clk.
- Frame result is latched at the end of the row3 slot:
  - NONE if no column was low in any row.
  - Key code K if exactly one row/column intersection was low.
  - MULTI if two or more were low (same row or different rows).
- FSM, evaluated only at frame end:
  - IDLE:
    - result K -> cand=K, cnt=1.
    - If DEBOUNCE_N==1, accept immediately; else go to CHECK.
    - NONE or MULTI -> stay in IDLE.
  - CHECK:
    - result==cand -> cnt+1; when cnt reaches DEBOUNCE_N, accept and go to HELD (cnt=0).
    - Any other result (NONE, MULTI, different key) -> IDLE, cnt=0. A different key is not adopted as the new candidate until the next frame.
  - HELD:
    - NONE -> rel+1; when rel reaches DEBOUNCE_N -> IDLE.
    - Any key or MULTI -> rel=0 and stay in HELD. No new pulse until a full release is seen.
- Accept action (on the clk after the frame-end evaluation):
  - digit d: tenkey = one-hot bit d for exactly 1 clk.
  - '#': close=1 for 1 clk.
  - '*': no output; the press is still debounced and held.
  - tenkey and close are never high together; both are 0 on every other cycle.
- Latency: a key stable from the start of frame f is accepted at the end of frame f+DEBOUNCE_N-1; the pulse appears 1 clk later.
- Synchronizer delay may push the first counted frame back by one frame when the key edge lands near a sample point.
- Reset mid-operation: everything returns to reset values immediately (asynchronous), and any pending pulse is dropped. A key held through reset deassertion is treated as a fresh press and re-accepted after debounce.
- busy = (state != IDLE), registered.

Decomposition:
- Shared package tenkey_pkg holds:
  - 4-bit key codes: KEY_0..KEY_9 = 4'h0..4'h9, KEY_STAR=4'hA, KEY_HASH=4'hB, KEY_MULTI=4'hE, KEY_NONE=4'hF. These codes match the lock core's 4'hF "no key" convention.
  - FSM state encoding IDLE/CHECK/HELD.
- One sub-module, sync2 (parameterised-width 2-FF synchronizer, asynchronous active-high reset to all-ones). Used for col_n.
- Scan, frame decode, FSM and output registers stay in tenkey_scan.

Test Plan (SCAN_DIV=4, DEBOUNCE_N=3, frame=16 clk):
1. Assert reset with keypad idle (col_n=3'b111) -> row_n=4'b1110, tenkey=0, close=0, busy=0; row_n rotates 1110->1101->1011->0111->1110 every 4 clk; no pulses over 20 frames.
2. Press '3' (col2 low whenever row0 driven) for 10 frames, then release -> exactly one tenkey=10'b0000001000 pulse, 1 clk wide, about 3 frames after press; busy drops 3 frames after release.
3. Bounce '7': pressed 2 frames, open 1 frame, pressed 6 frames -> single pulse tenkey=10'b0010000000, only after the third frame of the final stable run.
4. '1' and '5' held together for 10 frames -> no pulse, FSM stays IDLE; release '5' while keeping '1' -> one pulse 10'b0000000010.
5. Press '#' 5 frames -> close=1 for 1 clk, tenkey stays 0. Press '*' 5 frames -> no output, busy high. During a '4' hold, release 2 frames then re-press -> no second pulse (release needs 3 frames).
6. Assert reset while '9' is HELD -> tenkey=0, close=0, busy=0, row_n=1110 immediately; keep '9' pressed after reset deasserts -> one new pulse 10'b1000000000 after 3 frames.

Source files
------------

// File: rtl/tenkey_pkg.sv
// Key codes, FSM states and the 4x3 keypad map shared by the keypad scanner.
package tenkey_pkg;

  localparam logic [3:0] KEY_0     = 4'h0;
  localparam logic [3:0] KEY_1     = 4'h1;
  localparam logic [3:0] KEY_2     = 4'h2;
  localparam logic [3:0] KEY_3     = 4'h3;
  localparam logic [3:0] KEY_4     = 4'h4;
  localparam logic [3:0] KEY_5     = 4'h5;
  localparam logic [3:0] KEY_6     = 4'h6;
  localparam logic [3:0] KEY_7     = 4'h7;
  localparam logic [3:0] KEY_8     = 4'h8;
  localparam logic [3:0] KEY_9     = 4'h9;
  localparam logic [3:0] KEY_STAR  = 4'hA;
  localparam logic [3:0] KEY_HASH  = 4'hB;
  localparam logic [3:0] KEY_MULTI = 4'hE;
  localparam logic [3:0] KEY_NONE  = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    HELD  = 2'd2
  } state_e;

  function automatic logic [3:0] key_at(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] k;
    k = KEY_NONE;
    unique case ({row, col})
      4'b00_00: k = KEY_1;
      4'b00_01: k = KEY_2;
      4'b00_10: k = KEY_3;
      4'b01_00: k = KEY_4;
      4'b01_01: k = KEY_5;
      4'b01_10: k = KEY_6;
      4'b10_00: k = KEY_7;
      4'b10_01: k = KEY_8;
      4'b10_10: k = KEY_9;
      4'b11_00: k = KEY_STAR;
      4'b11_01: k = KEY_0;
      4'b11_10: k = KEY_HASH;
      default:  k = KEY_NONE;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/tenkey_scan_sync2.sv
// Two-flop synchronizer; resets to all-ones so idle active-low lines read as released.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/tenkey_scan.sv
// 4x3 keypad scanner with frame-level debounce; one registered pulse per accepted press.
module tenkey_scan
  import tenkey_pkg::*;
#(
  parameter int SCAN_DIV   = 8,
  parameter int DEBOUNCE_N = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [9:0] tenkey,
  output logic       close,
  output logic       busy
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_N + 1);

  logic [2:0]    col_s;
  logic [PW-1:0] presc_q;
  logic [1:0]    row_q;
  logic [3:0]    row_n_q;
  logic [1:0]    acc_n_q, acc_n_d;
  logic [3:0]    acc_key_q, acc_key_d;
  state_e        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [9:0]    tenkey_q, tenkey_d;
  logic          close_q, close_d;
  logic          busy_q;

  logic          slot_end, frame_end, accept;
  logic [1:0]    lows, base_n;
  logic [2:0]    sum_n;
  logic [3:0]    base_key, row_key, frame_res, acc_key;
  logic [CW-1:0] cnt_inc;

  sync2 #(.W(3)) u_col_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (col_n),
    .q_o   (col_s)
  );

  // Per-row sample: fold this row's low columns into the running frame tally (saturates at 2).
  always_comb begin
    slot_end  = (presc_q == PW'(SCAN_DIV - 1));
    frame_end = slot_end && (row_q == 2'd3);
    lows      = {1'b0, ~col_s[0]} + {1'b0, ~col_s[1]} + {1'b0, ~col_s[2]};
    base_n    = (row_q == 2'd0) ? 2'd0 : acc_n_q;
    base_key  = (row_q == 2'd0) ? KEY_NONE : acc_key_q;
    sum_n     = {1'b0, base_n} + {1'b0, lows};
    acc_n_d   = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
    if (!col_s[0])      row_key = key_at(row_q, 2'd0);
    else if (!col_s[1]) row_key = key_at(row_q, 2'd1);
    else if (!col_s[2]) row_key = key_at(row_q, 2'd2);
    else                row_key = KEY_NONE;
    acc_key_d = (base_n == 2'd0) ? row_key : base_key;
    if (acc_n_d == 2'd0)      frame_res = KEY_NONE;
    else if (acc_n_d == 2'd1) frame_res = acc_key_d;
    else                      frame_res = KEY_MULTI;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q   <= '0;
      row_q     <= 2'd0;
      row_n_q   <= 4'b1110;
      acc_n_q   <= 2'd0;
      acc_key_q <= KEY_NONE;
    end else begin
      presc_q <= slot_end ? '0 : presc_q + 1'b1;
      if (slot_end) begin
        row_q     <= row_q + 2'd1;
        row_n_q   <= {row_n_q[2:0], row_n_q[3]};
        acc_n_q   <= acc_n_d;
        acc_key_q <= acc_key_d;
      end
    end
  end

  // Debounce FSM; one counter serves as press count in CHECK and release count in HELD.
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    acc_key  = cand_q;
    cnt_inc  = cnt_q + 1'b1;
    tenkey_d = '0;
    close_d  = 1'b0;
    if (frame_end) begin
      unique case (state_q)
        IDLE: begin
          if (frame_res <= KEY_HASH) begin
            cand_d  = frame_res;
            acc_key = frame_res;
            if (DEBOUNCE_N == 1) begin
              accept  = 1'b1;
              state_d = HELD;
              cnt_d   = '0;
            end else begin
              state_d = CHECK;
              cnt_d   = CW'(1);
            end
          end
        end
        CHECK: begin
          if (frame_res == cand_q) begin
            if (cnt_inc == CW'(DEBOUNCE_N)) begin
              accept  = 1'b1;
              state_d = HELD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
          if (frame_res == KEY_NONE) begin
            if (cnt_inc == CW'(DEBOUNCE_N)) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    if (accept) begin
      if (acc_key <= KEY_9)         tenkey_d = 10'd1 << acc_key;
      else if (acc_key == KEY_HASH) close_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cand_q   <= KEY_NONE;
      cnt_q    <= '0;
      tenkey_q <= '0;
      close_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      tenkey_q <= tenkey_d;
      close_q  <= close_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign row_n  = row_n_q;
  assign tenkey = tenkey_q;
  assign close  = close_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_tenkey_scan.sv
// Directed bench for tenkey_scan with SCAN_DIV=4, DEBOUNCE_N=3 (16-clk frames).
module tb_tenkey_scan;

  logic       clk;
  logic       reset;
  logic [2:0] col_n;
  logic [3:0] row_n;
  logic [9:0] tenkey;
  logic       close;
  logic       busy;

  logic [11:0] keys;            // bit r*3+c = key at row r, column c is pressed
  int checks, errors;
  int cyc;
  int tk_cnt, cl_cnt, both_cnt, tk_cyc;
  logic [9:0] tk_last;

  tenkey_scan #(.SCAN_DIV(4), .DEBOUNCE_N(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .col_n  (col_n),
    .row_n  (row_n),
    .tenkey (tenkey),
    .close  (close),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!row_n[r] && keys[r*3+c]) col_n[c] = 1'b0;
  end

  always @(posedge clk) begin
    #2;
    cyc++;
    if (!reset) begin
      if (|tenkey) begin
        tk_cnt++;
        tk_last = tenkey;
        tk_cyc  = cyc;
      end
      if (close) cl_cnt++;
      if (close && |tenkey) both_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    tk_cnt = 0; cl_cnt = 0; both_cnt = 0; tk_last = '0; tk_cyc = 0;
  endtask

  task automatic press(input int r, input int c);
    keys[r*3+c] = 1'b1;
  endtask

  task automatic rel(input int r, input int c);
    keys[r*3+c] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int rot_err, c0, lat;
    logic [3:0] exp_row;
    checks = 0; errors = 0; cyc = 0; keys = '0;
    clr();
    reset = 1'b1;
    wait_cyc(3);
    chk("rst_row_n", {28'd0, row_n}, 32'hE);
    chk("rst_tenkey", {22'd0, tenkey}, 32'h0);
    chk("rst_close", {31'd0, close}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    reset = 1'b0;

    // 1: idle keypad, row rotation and silence
    rot_err = 0;
    for (int k = 1; k <= 320; k++) begin
      @(negedge clk);
      exp_row = ~(4'b0001 << ((k / 4) % 4));
      if (row_n !== exp_row) rot_err++;
    end
    chk("row_rotation_errs", rot_err, 0);
    chk("idle_pulses", tk_cnt + cl_cnt, 0);

    // 2: '3' held 10 frames
    clr(); c0 = cyc;
    press(0, 2);
    wait_cyc(160);
    chk("k3_count", tk_cnt, 1);
    chk("k3_value", {22'd0, tk_last}, 32'h008);
    lat = tk_cyc - c0;
    chk("k3_latency_ok", (lat >= 30 && lat <= 70), 1);
    chk("k3_busy_held", {31'd0, busy}, 1);
    rel(0, 2);
    wait_cyc(16);
    chk("k3_busy_rel1", {31'd0, busy}, 1);
    wait_cyc(64);
    chk("k3_busy_rel5", {31'd0, busy}, 0);
    chk("k3_no_extra", tk_cnt, 1);

    // 3: bouncing '7'
    clr();
    press(2, 0); wait_cyc(32);
    rel(2, 0);   wait_cyc(16);
    chk("k7_bounce_none", tk_cnt, 0);
    c0 = cyc;
    press(2, 0); wait_cyc(96);
    chk("k7_count", tk_cnt, 1);
    chk("k7_value", {22'd0, tk_last}, 32'h080);
    chk("k7_after_3rd_frame", ((tk_cyc - c0) >= 32), 1);
    rel(2, 0); wait_cyc(96);

    // 4: '1'+'5' together, then '1' alone
    clr();
    press(0, 0); press(1, 1); wait_cyc(160);
    chk("multi_count", tk_cnt, 0);
    chk("multi_busy", {31'd0, busy}, 0);
    rel(1, 1); wait_cyc(96);
    chk("k1_count", tk_cnt, 1);
    chk("k1_value", {22'd0, tk_last}, 32'h002);
    rel(0, 0); wait_cyc(96);

    // 5: '#', '*', and a short release during '4'
    clr();
    press(3, 2); wait_cyc(80);
    chk("hash_close", cl_cnt, 1);
    chk("hash_tenkey", tk_cnt, 0);
    rel(3, 2); wait_cyc(96);
    clr();
    press(3, 0); wait_cyc(80);
    chk("star_tenkey", tk_cnt, 0);
    chk("star_close", cl_cnt, 0);
    chk("star_busy", {31'd0, busy}, 1);
    rel(3, 0); wait_cyc(96);
    chk("star_busy_rel", {31'd0, busy}, 0);
    clr();
    press(1, 0); wait_cyc(96);
    rel(1, 0);   wait_cyc(32);
    press(1, 0); wait_cyc(96);
    chk("k4_count", tk_cnt, 1);
    chk("k4_value", {22'd0, tk_last}, 32'h010);
    chk("never_both", both_cnt, 0);
    rel(1, 0); wait_cyc(96);

    // 6: reset while '9' held
    clr();
    press(2, 2); wait_cyc(96);
    chk("k9_busy", {31'd0, busy}, 1);
    chk("k9_first", tk_cnt, 1);
    wait_cyc(5);
    reset = 1'b1;
    #1;
    chk("mid_rst_row_n", {28'd0, row_n}, 32'hE);
    chk("mid_rst_tenkey", {22'd0, tenkey}, 32'h0);
    chk("mid_rst_close", {31'd0, close}, 32'h0);
    chk("mid_rst_busy", {31'd0, busy}, 32'h0);
    wait_cyc(3);
    reset = 1'b0;
    clr();
    wait_cyc(96);
    chk("k9_repress_count", tk_cnt, 1);
    chk("k9_repress_value", {22'd0, tk_last}, 32'h200);
    rel(2, 2); wait_cyc(16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
